// File: rtl/gouram_datatypes.sv
// Shared types for the trace validity filter: history entry layout, the
// "no edge found" sentinel and the query engine state encoding.
package gouram_datatypes;

   typedef struct packed {
      logic        active;
      logic [31:0] timestamp;
   } history_entry_t;

   localparam logic signed [31:0] NOT_FOUND = -32'sd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TIME_SCAN,
      ST_VALUE_FETCH,
      ST_DONE
   } engine_state_t;

endpackage

// File: rtl/signal_history_ring.sv
// Circular sample history: one write per cycle at the write pointer, one
// registered random read, and a fill count that saturates at DEPTH.
module signal_history_ring
   import gouram_datatypes::*;
#(
   parameter int DEPTH = 128,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  history_entry_t   wr_entry,
   input  logic [PTR_W-1:0] rd_addr,
   output history_entry_t   rd_entry,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [CNT_W-1:0] fill_cnt
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   history_entry_t mem [DEPTH];

   // Read and write share an edge, so a read of the slot being overwritten
   // returns the old sample; the scan relies on this when the ring is full.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         mem[wr_ptr] <= wr_entry;
      end
      rd_entry <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         fill_cnt <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(1);
         if (fill_cnt != FULL) begin
            fill_cnt <= fill_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/signal_tracker.sv
// Per-signal history recorder with a query engine answering "edge times of the
// first active phase in a look-back window" and "signal value K cycles ago".
//
// state          | meaning
// ST_IDLE        | sampling only; accepts a request once the previous one was released
// ST_TIME_SCAN   | walks the frozen history oldest to newest, one entry per cycle
// ST_VALUE_FETCH | two-cycle lookup of the sample K cycles before the request
// ST_DONE        | result valid and held until the originating request drops
module signal_tracker
   import gouram_datatypes::*;
#(
   parameter int SIGNAL_WIDTH       = 1,
   parameter int SIGNAL_BUFFER_SIZE = 128
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             counter,
   input  logic [SIGNAL_WIDTH-1:0] signal,
   input  logic [31:0]             value_in,
   input  logic                    recalculate_time,
   output logic signed [31:0]      time_out_0,
   output logic signed [31:0]      time_out_1,
   input  logic [31:0]             cycles_back_to_recall,
   input  logic                    recalculate_back_cycle,
   output logic                    signal_recall,
   output logic                    data_valid
);

   localparam int PTR_W = $clog2(SIGNAL_BUFFER_SIZE);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(SIGNAL_BUFFER_SIZE);

   history_entry_t   wr_entry;
   history_entry_t   rd_entry;
   logic [PTR_W-1:0] rd_addr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] fill_cnt;

   engine_state_t    state_q, state_d;
   logic [31:0]      t_snap_q, l_snap_q, k_snap_q;
   logic [CNT_W-1:0] fill_snap_q, avail_q, scan_cnt_q;
   logic [PTR_W-1:0] scan_ptr_q;
   logic             origin_time_q, rearm_q;
   logic             cur_active_q, fetch_val_q, fetch_cnt_q;

   logic             rise_found_q, rise_found_d;
   logic             end_found_q, end_found_d;
   logic             prev_valid_q, prev_valid_d;
   logic             prev_active_q, prev_active_d;
   logic [31:0]      rise_ts_q, rise_ts_d;
   logic [31:0]      run_last_q, run_last_d;
   logic [31:0]      end_ts_q, end_ts_d;

   logic [31:0]      age;
   logic             in_win, scan_live, scan_last;
   logic             start_time, start_value, origin_req;

   assign wr_entry.active    = |signal;
   assign wr_entry.timestamp = counter;

   signal_history_ring #(
      .DEPTH (SIGNAL_BUFFER_SIZE)
   ) u_ring (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_entry (wr_entry),
      .rd_addr  (rd_addr),
      .rd_entry (rd_entry),
      .wr_ptr   (wr_ptr),
      .fill_cnt (fill_cnt)
   );

   assign start_time  = (state_q == ST_IDLE) && !rearm_q && recalculate_time;
   assign start_value = (state_q == ST_IDLE) && !rearm_q && !recalculate_time
                        && recalculate_back_cycle;
   assign origin_req  = origin_time_q ? recalculate_time : recalculate_back_cycle;
   assign scan_live   = (fill_snap_q != '0);
   assign scan_last   = (scan_cnt_q == fill_snap_q - CNT_W'(1));
   assign data_valid  = (state_q == ST_DONE);

   // The first read is issued in the request cycle itself so the oldest entry
   // is fetched before the sampler can overwrite it.
   always_comb begin
      rd_addr = scan_ptr_q;
      if (state_q == ST_IDLE) begin
         if (recalculate_time) begin
            rd_addr = wr_ptr - fill_cnt[PTR_W-1:0];
         end else begin
            rd_addr = wr_ptr - cycles_back_to_recall[PTR_W-1:0];
         end
      end
   end

   // Window membership uses the distance back from T, so T-L never underflows.
   always_comb begin
      rise_found_d  = rise_found_q;
      end_found_d   = end_found_q;
      prev_valid_d  = prev_valid_q;
      prev_active_d = prev_active_q;
      rise_ts_d     = rise_ts_q;
      run_last_d    = run_last_q;
      end_ts_d      = end_ts_q;
      age           = t_snap_q - rd_entry.timestamp;
      in_win        = scan_live && (age != 32'd0) && (age <= l_snap_q);
      if (scan_live) begin
         prev_valid_d  = 1'b1;
         prev_active_d = rd_entry.active;
      end
      if (in_win) begin
         if (!rise_found_q) begin
            if (rd_entry.active && !(prev_valid_q && prev_active_q)) begin
               rise_found_d = 1'b1;
               rise_ts_d    = rd_entry.timestamp;
               run_last_d   = rd_entry.timestamp;
            end
         end else if (!end_found_q) begin
            if (rd_entry.active) begin
               run_last_d = rd_entry.timestamp;
            end else begin
               end_found_d = 1'b1;
               end_ts_d    = run_last_q;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_time) begin
               state_d = ST_TIME_SCAN;
            end else if (start_value) begin
               state_d = ST_VALUE_FETCH;
            end
         end
         ST_TIME_SCAN: begin
            if (!scan_live || scan_last) begin
               state_d = ST_DONE;
            end
         end
         ST_VALUE_FETCH: begin
            if (fetch_cnt_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!origin_req) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         time_out_0    <= NOT_FOUND;
         time_out_1    <= NOT_FOUND;
         signal_recall <= 1'b0;
         rearm_q       <= 1'b0;
         origin_time_q <= 1'b0;
         t_snap_q      <= '0;
         l_snap_q      <= '0;
         k_snap_q      <= '0;
         fill_snap_q   <= '0;
         avail_q       <= '0;
         scan_cnt_q    <= '0;
         scan_ptr_q    <= '0;
         cur_active_q  <= 1'b0;
         fetch_val_q   <= 1'b0;
         fetch_cnt_q   <= 1'b0;
         rise_found_q  <= 1'b0;
         end_found_q   <= 1'b0;
         prev_valid_q  <= 1'b0;
         prev_active_q <= 1'b0;
         rise_ts_q     <= '0;
         run_last_q    <= '0;
         end_ts_q      <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (!recalculate_time && !recalculate_back_cycle) begin
                  rearm_q <= 1'b0;
               end
               if (start_time || start_value) begin
                  origin_time_q <= start_time;
                  t_snap_q      <= counter;
                  l_snap_q      <= value_in;
                  k_snap_q      <= cycles_back_to_recall;
                  fill_snap_q   <= fill_cnt;
                  avail_q       <= (fill_cnt == FULL) ? FULL : fill_cnt + CNT_W'(1);
                  cur_active_q  <= |signal;
                  scan_ptr_q    <= rd_addr + PTR_W'(1);
                  scan_cnt_q    <= '0;
                  fetch_cnt_q   <= 1'b0;
                  rise_found_q  <= 1'b0;
                  end_found_q   <= 1'b0;
                  prev_valid_q  <= 1'b0;
                  prev_active_q <= 1'b0;
               end
            end
            ST_TIME_SCAN: begin
               rise_found_q  <= rise_found_d;
               end_found_q   <= end_found_d;
               prev_valid_q  <= prev_valid_d;
               prev_active_q <= prev_active_d;
               rise_ts_q     <= rise_ts_d;
               run_last_q    <= run_last_d;
               end_ts_q      <= end_ts_d;
               scan_ptr_q    <= scan_ptr_q + PTR_W'(1);
               scan_cnt_q    <= scan_cnt_q + CNT_W'(1);
               if (state_d == ST_DONE) begin
                  time_out_0 <= rise_found_d ? $signed(rise_ts_d) : NOT_FOUND;
                  time_out_1 <= (rise_found_d && end_found_d) ? $signed(end_ts_d) : NOT_FOUND;
               end
            end
            ST_VALUE_FETCH: begin
               fetch_cnt_q <= 1'b1;
               if (!fetch_cnt_q) begin
                  if (k_snap_q == 32'd0) begin
                     fetch_val_q <= cur_active_q;
                  end else if (k_snap_q < 32'(avail_q)) begin
                     fetch_val_q <= rd_entry.active;
                  end else begin
                     fetch_val_q <= 1'b0;
                  end
               end else begin
                  signal_recall <= fetch_val_q;
               end
            end
            ST_DONE: begin
               if (state_d == ST_IDLE) begin
                  rearm_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_signal_tracker.sv
// Directed and randomized checks of signal_tracker against a timestamp-indexed
// reference history kept in a queue.
module tb_signal_tracker;

   localparam int DEPTH = 128;

   typedef struct {
      bit          act;
      int unsigned ts;
   } samp_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [31:0]        counter = '0;
   logic [0:0]         signal = '0;
   logic [31:0]        value_in = '0;
   logic               recalculate_time = 1'b0;
   logic signed [31:0] time_out_0, time_out_1;
   logic [31:0]        cycles_back_to_recall = '0;
   logic               recalculate_back_cycle = 1'b0;
   logic               signal_recall, data_valid;

   int    total = 0;
   int    bad = 0;
   bit    rand_sig = 0;
   samp_t hist[$];

   signal_tracker #(
      .SIGNAL_WIDTH       (1),
      .SIGNAL_BUFFER_SIZE (DEPTH)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .counter                (counter),
      .signal                 (signal),
      .value_in               (value_in),
      .recalculate_time       (recalculate_time),
      .time_out_0             (time_out_0),
      .time_out_1             (time_out_1),
      .cycles_back_to_recall  (cycles_back_to_recall),
      .recalculate_back_cycle (recalculate_back_cycle),
      .signal_recall          (signal_recall),
      .data_valid             (data_valid)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      samp_t s;
      @(posedge clk);
      if (!rst_n) begin
         hist.delete();
      end else begin
         s.act = (signal != 0);
         s.ts  = counter;
         hist.push_back(s);
         if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      @(negedge clk);
      counter = counter + 1;
      if (rand_sig && $urandom_range(0, 3) == 0) signal = ~signal;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // First active sample in the window whose preceding stored sample is
   // inactive (or absent); the end is the sample just before the next inactive.
   function automatic void model_time(input int unsigned t, input int unsigned l,
                                      output int r0, output int r1);
      int rise_i = -1;
      r0 = -1;
      r1 = -1;
      for (int i = 0; i < hist.size(); i++) begin
         int unsigned age = t - hist[i].ts;
         if (age == 0 || age > l) continue;
         if (hist[i].act && (i == 0 || !hist[i-1].act)) begin
            rise_i = i;
            break;
         end
      end
      if (rise_i >= 0) begin
         r0 = int'(hist[rise_i].ts);
         for (int j = rise_i + 1; j < hist.size(); j++) begin
            if (!hist[j].act) begin
               r1 = int'(hist[j-1].ts);
               break;
            end
         end
      end
   endfunction

   function automatic bit model_value(input int unsigned t, input int unsigned k);
      foreach (hist[i]) begin
         if (hist[i].ts == t - k) return hist[i].act;
      end
      return 1'b0;
   endfunction

   task automatic wait_valid(input string tag, input int budget, output int n);
      n = 0;
      while (data_valid !== 1'b1 && n < budget) begin
         cyc();
         n++;
      end
      chk({tag, ":valid"}, 32'(data_valid), 1);
   endtask

   task automatic release_req(input string tag);
      recalculate_time = 1'b0;
      recalculate_back_cycle = 1'b0;
      cyc();
      chk({tag, ":drop"}, 32'(data_valid), 0);
      cyc();
   endtask

   task automatic time_query(input string tag, input int unsigned l, input bit use_model,
                             input int e0, input int e1);
      int x0, x1, n;
      x0 = e0;
      x1 = e1;
      if (use_model) model_time(counter, l, x0, x1);
      value_in = l;
      recalculate_time = 1'b1;
      cyc();
      wait_valid(tag, 200, n);
      chk({tag, ":lat"}, 32'(n <= DEPTH + 1), 1);
      chk({tag, ":t0"}, time_out_0, x0);
      chk({tag, ":t1"}, time_out_1, x1);
   endtask

   task automatic value_query(input string tag, input int unsigned k, input bit use_model,
                              input bit e);
      int unsigned t;
      int          n;
      bit          x;
      t = counter;
      x = e;
      cycles_back_to_recall = k;
      recalculate_back_cycle = 1'b1;
      cyc();
      if (use_model) x = model_value(t, k);
      wait_valid(tag, 10, n);
      chk({tag, ":lat"}, n, 2);
      chk({tag, ":recall"}, 32'(signal_recall), 32'(x));
   endtask

   initial begin
      int unsigned b;
      repeat (5) cyc();
      rst_n = 1'b1;
      repeat (10) cyc();
      chk("idle:valid", 32'(data_valid), 0);
      chk("idle:t0", time_out_0, -1);
      chk("idle:t1", time_out_1, -1);
      chk("idle:recall", 32'(signal_recall), 0);

      while (counter < 40) begin
         signal = (counter >= 20 && counter <= 24);
         cyc();
      end
      signal = 1'b0;
      time_query("pulse", 30, 0, 20, 24);

      repeat (5) begin
         cyc();
         chk("hold:valid", 32'(data_valid), 1);
      end
      chk("hold:t0", time_out_0, 20);
      chk("hold:t1", time_out_1, 24);
      recalculate_time = 1'b0;
      cyc();
      chk("hold:drop", 32'(data_valid), 0);
      recalculate_time = 1'b1;
      repeat (4) cyc();
      chk("rearm:valid", 32'(data_valid), 0);
      recalculate_time = 1'b0;
      repeat (2) cyc();

      value_in = 1000;
      recalculate_time = 1'b1;
      repeat (6) cyc();
      chk("midscan:valid", 32'(data_valid), 0);
      rst_n = 1'b0;
      recalculate_time = 1'b0;
      cyc();
      chk("rst:valid", 32'(data_valid), 0);
      chk("rst:t0", time_out_0, -1);
      chk("rst:t1", time_out_1, -1);
      rst_n = 1'b1;
      repeat (8) cyc();
      time_query("post_rst", 1000, 0, -1, -1);
      release_req("post_rst");

      b = counter;
      signal = 1'b0;
      while (counter < b + 35) cyc();
      signal = 1'b1;
      while (counter < b + 40) cyc();
      time_query("rise", 10, 0, int'(b + 35), -1);
      release_req("rise");
      time_query("allhigh", 3, 0, -1, -1);
      release_req("allhigh");

      b = counter;
      signal = 1'b0;
      while (counter < b + 50) cyc();
      signal = 1'b1; cyc();
      signal = 1'b0; cyc();
      signal = 1'b1; cyc();
      signal = 1'b0;
      value_query("k2", 2, 0, 1'b0);
      release_req("k2");
      signal = 1'b1; cyc();
      signal = 1'b0;
      value_query("k1", 1, 0, 1'b1);
      release_req("k1");
      value_query("k500", 500, 0, 1'b0);
      release_req("k500");
      signal = 1'b1;
      value_query("k0", 0, 0, 1'b1);
      release_req("k0");

      rand_sig = 1;
      repeat (30) begin
         repeat ($urandom_range(1, 60)) cyc();
         if ($urandom_range(0, 1) == 1) begin
            recalculate_back_cycle = 1'($urandom_range(0, 1));
            time_query("rnd_time", $urandom_range(0, 160), 1, 0, 0);
         end else begin
            value_query("rnd_value", $urandom_range(0, 140), 1, 1'b0);
         end
         release_req("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
